// File: rtl/membus_arbiter_pkg.sv
// rtl/membus_arbiter_pkg.sv - shared types and width defaults for the memory bus arbiter
package membus_arbiter_pkg;

  localparam int RAM_ADDR_W  = 32;
  localparam int RAM_DATA_W  = 32;
  localparam int DEF_N_CH    = 2;
  localparam int DEF_TIMEOUT = 15;

  typedef logic [RAM_ADDR_W-1:0] ram_addr_t;
  typedef logic [RAM_DATA_W-1:0] ram_data_t;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } arb_state_t;

  // Index width that stays legal for a single channel.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/membus_arbiter_if.sv
// rtl/membus_arbiter_if.sv - single-outstanding slave memory bus (ce/we/addr/wdata/rdata)
interface i_membus #(
  parameter int ADDR_W = membus_arbiter_pkg::RAM_ADDR_W,
  parameter int DATA_W = membus_arbiter_pkg::RAM_DATA_W
);
  logic              ce;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;

  modport master (output ce, we, addr, wdata, input rdata);
  modport slave  (input ce, we, addr, wdata, output rdata);
endinterface

// File: rtl/membus_arbiter_rr_picker.sv
// rtl/membus_arbiter_rr_picker.sv - combinational round-robin pick: first request after the pointer
module membus_rr_picker #(
  parameter int N_CH  = 2,
  parameter int IDX_W = 1
) (
  input  logic [N_CH-1:0]  i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [N_CH-1:0]  o_grant,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_valid
);

  int               w_cand;
  logic [IDX_W-1:0] w_sel;

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_valid = 1'b0;
    w_cand  = 0;
    w_sel   = '0;
    for (int k = 1; k <= N_CH; k++) begin
      w_cand = int'(i_ptr) + k;
      if (w_cand >= N_CH) w_cand = w_cand - N_CH;
      w_sel = IDX_W'(w_cand);
      if (!o_valid && i_req[w_sel]) begin
        o_valid        = 1'b1;
        o_grant[w_sel] = 1'b1;
        o_idx          = w_sel;
      end
    end
  end

endmodule

// File: rtl/membus_arbiter.sv
// rtl/membus_arbiter.sv - N-channel arbiter onto one slave with timeout completion
// MEMBUS_ARB_FIXED_PRIO_EN selects fixed lowest-index priority instead of round-robin.
module membus_arbiter
  import membus_arbiter_pkg::*;
#(
  parameter int N_CH    = DEF_N_CH,
  parameter int ADDR_W  = RAM_ADDR_W,
  parameter int DATA_W  = RAM_DATA_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_CH-1:0]          i_m_req,
  input  logic [N_CH-1:0]          i_m_we,
  input  logic [N_CH*ADDR_W-1:0]   i_m_addr,
  input  logic [N_CH*DATA_W-1:0]   i_m_wdata,
  output logic [N_CH-1:0]          o_m_ack,
  output logic [N_CH-1:0]          o_m_err,
  output logic [DATA_W-1:0]        o_m_rdata,
  i_membus.master                  bus,
  input  logic                     i_s_ready
);

  localparam int         IDX_W     = idx_width(N_CH);
  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

  arb_state_t       r_state;
  logic [7:0]       r_cnt;
  logic [N_CH-1:0]  r_grant;
  logic [N_CH-1:0]  w_elig;
  logic [N_CH-1:0]  w_grant;
  logic [IDX_W-1:0] w_idx;
  logic [IDX_W-1:0] w_ptr;
  logic             w_valid;

`ifdef MEMBUS_ARB_FIXED_PRIO_EN
  // Pinning the pointer at the last index makes the picker scan from channel 0 every time.
  assign w_ptr  = IDX_W'(N_CH - 1);
  assign w_elig = i_m_req;
`else
  logic [IDX_W-1:0] r_ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= IDX_W'(N_CH - 1);
    end else if (r_state == IDLE && w_valid) begin
      r_ptr <= w_idx;
    end
  end

  assign w_ptr  = r_ptr;
  // A channel still holding m_req in its ack cycle must not win a second, unwanted slot.
  assign w_elig = i_m_req & ~o_m_ack;
`endif

  membus_rr_picker #(
    .N_CH  (N_CH),
    .IDX_W (IDX_W)
  ) u_picker (
    .i_req   (w_elig),
    .i_ptr   (w_ptr),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_valid (w_valid)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_grant   <= '0;
      bus.ce    <= 1'b0;
      bus.we    <= 1'b0;
      bus.addr  <= '0;
      bus.wdata <= '0;
      o_m_ack   <= '0;
      o_m_err   <= '0;
      o_m_rdata <= '0;
    end else begin
      o_m_ack <= '0;
      o_m_err <= '0;
      case (r_state)
        IDLE: begin
          if (w_valid) begin
            r_state   <= ACCESS;
            r_cnt     <= '0;
            r_grant   <= w_grant;
            bus.ce    <= 1'b1;
            bus.we    <= i_m_we[w_idx];
            bus.addr  <= i_m_addr[w_idx*ADDR_W +: ADDR_W];
            bus.wdata <= i_m_wdata[w_idx*DATA_W +: DATA_W];
          end
        end
        ACCESS: begin
          // s_ready is checked first so a completion on the timeout cycle is not an error.
          if (i_s_ready) begin
            r_state   <= IDLE;
            bus.ce    <= 1'b0;
            o_m_ack   <= r_grant;
            o_m_rdata <= bus.rdata;
          end else if (r_cnt == TIMEOUT_C) begin
            r_state   <= IDLE;
            bus.ce    <= 1'b0;
            o_m_ack   <= r_grant;
            o_m_err   <= r_grant;
            o_m_rdata <= '0;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_membus_arbiter.sv
// tb/tb_membus_arbiter.sv - directed self-checking bench for membus_arbiter (N_CH=4, TIMEOUT=4)
module tb_membus_arbiter;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 4;
`ifdef MEMBUS_ARB_FIXED_PRIO_EN
  localparam logic [3:0] ALT01 = 4'd0;
  localparam logic [3:0] ALT02 = 4'd0;
`else
  localparam logic [3:0] ALT01 = 4'd1;
  localparam logic [3:0] ALT02 = 4'd2;
`endif

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req;
  logic [N-1:0]    we;
  logic [N*AW-1:0] addr;
  logic [N*DW-1:0] wdata;
  logic [N-1:0]    ack;
  logic [N-1:0]    err;
  logic [DW-1:0]   rdata;
  logic            s_ready;

  int         errors = 0;
  int         checks = 0;
  int         nack;
  logic [3:0] exp_ch;

  always #5 clk = ~clk;

  i_membus #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  membus_arbiter #(
    .N_CH    (N),
    .ADDR_W  (AW),
    .DATA_W  (DW),
    .TIMEOUT (TO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .i_m_req   (req),
    .i_m_we    (we),
    .i_m_addr  (addr),
    .i_m_wdata (wdata),
    .o_m_ack   (ack),
    .o_m_err   (err),
    .o_m_rdata (rdata),
    .bus       (bus),
    .i_s_ready (s_ready)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    req = '0; we = '0; addr = '0; wdata = '0; s_ready = 1'b0; bus.rdata = '0;
    tick();
    tick();
    chk("rst_ce",    bus.ce,    1'b0);
    chk("rst_we",    bus.we,    1'b0);
    chk("rst_addr",  bus.addr,  '0);
    chk("rst_wdata", bus.wdata, '0);
    chk("rst_ack",   ack,       '0);
    chk("rst_err",   err,       '0);
    chk("rst_rdata", rdata,     '0);
    rst = 1'b0;

    // Single read, minimum latency: req cycle 0, s_ready cycle 1, ack cycle 2.
    req = 4'b0001; addr[31:0] = 32'h100;
    tick();
    chk("rd_ce",   bus.ce,   1'b1);
    chk("rd_addr", bus.addr, 32'h100);
    chk("rd_we",   bus.we,   1'b0);
    chk("rd_ack0", ack,      4'b0000);
    s_ready = 1'b1; bus.rdata = 32'hDEADBEEF;
    tick();
    chk("rd_ack",   ack,    4'b0001);
    chk("rd_rdata", rdata,  32'hDEADBEEF);
    chk("rd_err",   err,    4'b0000);
    chk("rd_ce_lo", bus.ce, 1'b0);
    s_ready = 1'b0; bus.rdata = '0;
`ifndef MEMBUS_ARB_FIXED_PRIO_EN
    tick();
    chk("mask_ce",  bus.ce, 1'b0);
    chk("mask_ack", ack,    4'b0000);
`endif
    req = '0;
    tick();
    chk("idle_ce", bus.ce, 1'b0);

    // Contention ch0/ch1 with s_ready always high.
    do_reset();
    req = 4'b0011; s_ready = 1'b1; bus.rdata = 32'h55;
    exp_ch = 4'd0; nack = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("cont_onehot", $onehot0(ack), 1'b1);
      if (ack != '0) begin
        chk("cont_grant", ack, 4'b0001 << exp_ch);
        exp_ch = exp_ch ^ ALT01;
        nack++;
      end
    end
    chk("cont_count", nack, 4);
    req = '0; s_ready = 1'b0;
    tick();
    chk("cont_idle", bus.ce, 1'b0);

    // Timeout on a ch1 write; req dropped mid-access must still complete.
    req = 4'b0010; we = 4'b0010; addr[63:32] = 32'h200; wdata[63:32] = 32'h12345678;
    tick();
    chk("to_ce",    bus.ce,    1'b1);
    chk("to_we",    bus.we,    1'b1);
    chk("to_addr",  bus.addr,  32'h200);
    chk("to_wdata", bus.wdata, 32'h12345678);
    req = '0;
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk("to_wait_ack", ack,    4'b0000);
      chk("to_hold_ce",  bus.ce, 1'b1);
    end
    tick();
    chk("to_ack",   ack,    4'b0010);
    chk("to_err",   err,    4'b0010);
    chk("to_rdata", rdata,  32'h0);
    chk("to_ce_lo", bus.ce, 1'b0);
    tick();
    chk("to_ack_pulse", ack, 4'b0000);
    chk("to_err_pulse", err, 4'b0000);
    we = '0;

    // s_ready arrives on the cycle the counter reaches TIMEOUT.
    req = 4'b0001; addr[31:0] = 32'h300; bus.rdata = 32'hCAFEF00D;
    tick();
    chk("race_ce", bus.ce, 1'b1);
    req = '0;
    repeat (4) tick();
    chk("race_pre_ack", ack, 4'b0000);
    s_ready = 1'b1;
    tick();
    chk("race_ack",   ack,   4'b0001);
    chk("race_err",   err,   4'b0000);
    chk("race_rdata", rdata, 32'hCAFEF00D);
    s_ready = 1'b0;

    // Asynchronous reset in the middle of a ch2 write.
    req = 4'b0100; we = 4'b0100; addr[95:64] = 32'h400; wdata[95:64] = 32'hA5A5A5A5;
    tick();
    chk("ar_ce",    bus.ce,    1'b1);
    chk("ar_wdata", bus.wdata, 32'hA5A5A5A5);
    req = '0; we = '0;
    #2 rst = 1'b1;
    #1;
    chk("ar_ce_lo", bus.ce,    1'b0);
    chk("ar_we",    bus.we,    1'b0);
    chk("ar_addr",  bus.addr,  32'h0);
    chk("ar_wdata0", bus.wdata, 32'h0);
    chk("ar_rdata", rdata,     32'h0);
    chk("ar_ack",   ack,       4'b0000);
    #2 rst = 1'b0;
    s_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("ar_no_ack", ack,    4'b0000);
      chk("ar_no_ce",  bus.ce, 1'b0);
    end
    s_ready = 1'b0;

    // ch0 and ch2 continuously: alternate under round-robin, ch0 only under fixed priority.
    req = 4'b0101; s_ready = 1'b1;
    exp_ch = 4'd0; nack = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("prio_onehot", $onehot0(ack), 1'b1);
      if (ack != '0) begin
        chk("prio_grant", ack, 4'b0001 << exp_ch);
        exp_ch = exp_ch ^ ALT02;
        nack++;
      end
    end
    chk("prio_count", nack, 4);
    req = '0; s_ready = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
